// File: rtl/prio_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arb_pkg
//  Description : Shared sizes and FSM state type for the 4-way priority
//                arbiter (prio_arbiter, arb_pick).
//  Revision    : 1.0  initial release
// ============================================================================
package prio_arb_pkg;

    localparam int N_REQ  = 4;   // number of requesters
    localparam int ID_W   = 2;   // width of an encoded requester index
    localparam int HOLD_W = 8;   // width of the grant hold counter

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : prio_arb_pkg
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational pick of one requester out of an eligible
//                vector. The search starts at index ptr and walks either
//                upward (ASCEND=1, rotating order ptr, ptr+1, ...) or
//                downward (ASCEND=0, order ptr, ptr-1, ...), wrapping mod
//                N_REQ. Returns one-hot pick, encoded index and any-flag.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_pick
    import prio_arb_pkg::*;
#(
    parameter bit ASCEND = 1'b0
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    // Scan from lowest to highest priority so the highest-priority hit
    // is the last one written and therefore wins.
    always_comb begin
        logic [ID_W-1:0] w_cand;
        w_cand = '0;
        idx    = '0;
        any    = 1'b0;
        pick   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = ASCEND ? (ptr + ID_W'(i)) : (ptr - ID_W'(i));
            if (eligible[w_cand]) begin
                idx = w_cand;
                any = 1'b1;
            end
        end
        if (any) begin
            pick = N_REQ'(1) << idx;
        end
    end

endmodule : arb_pick
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter
//  Description : 4-requester arbiter with registered one-hot grant, grant
//                hold limit (HOLD_MAX) with one-shot masking of the expired
//                requester, and a mandatory idle cycle between grants.
//                Optional macro PRIO_ARB_RR_EN enables rotating priority;
//                without it priority is fixed 3 > 2 > 1 > 0.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8     // legal range 2..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             expired
);

    state_t             r_state,     w_state_next;
    logic [N_REQ-1:0]   r_gnt,       w_gnt_next;
    logic [ID_W-1:0]    r_gnt_id,    w_gnt_id_next;
    logic               r_gnt_valid, w_gnt_valid_next;
    logic               r_expired,   w_expired_next;
    logic [HOLD_W-1:0]  r_hold,      w_hold_next;
    logic [N_REQ-1:0]   r_mask,      w_mask_next;

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_sel;
    logic [N_REQ-1:0]   w_pick;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [ID_W-1:0]    w_ptr;

    // Masked requester is skipped unless it is the only one asking.
    assign w_elig = req & ~r_mask;
    assign w_sel  = (|w_elig) ? w_elig : req;

`ifdef PRIO_ARB_RR_EN
    localparam bit c_ASCEND = 1'b1;
    logic [ID_W-1:0] r_ptr, w_ptr_next;

    assign w_ptr = r_ptr;

    // Rotation pointer: after a grant, the index above the winner leads.
    always_comb begin
        w_ptr_next = r_ptr;
        if ((r_state == IDLE) && w_any) begin
            w_ptr_next = w_idx + ID_W'(1);
        end
    end

    // Rotation pointer register; reset makes bit 3 the highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= ID_W'(N_REQ - 1);
        end else begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    localparam bit c_ASCEND = 1'b0;

    // Fixed priority: search downward from the top index.
    assign w_ptr = ID_W'(N_REQ - 1);
`endif

    arb_pick #(
        .ASCEND   (c_ASCEND)
    ) u_pick (
        .eligible (w_sel),
        .ptr      (w_ptr),
        .pick     (w_pick),
        .idx      (w_idx),
        .any      (w_any)
    );

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_next     = r_state;
        w_gnt_next       = r_gnt;
        w_gnt_id_next    = r_gnt_id;
        w_gnt_valid_next = r_gnt_valid;
        w_expired_next   = 1'b0;
        w_hold_next      = r_hold;
        w_mask_next      = r_mask;

        case (r_state)
            IDLE: begin
                // The mask only ever influences one arbitration.
                w_mask_next = '0;
                if (w_any) begin
                    w_state_next     = GRANT;
                    w_gnt_next       = w_pick;
                    w_gnt_id_next    = w_idx;
                    w_gnt_valid_next = 1'b1;
                    w_hold_next      = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!req[r_gnt_id]) begin
                    // Release wins over a coincident expiry.
                    w_state_next     = IDLE;
                    w_gnt_next       = '0;
                    w_gnt_id_next    = '0;
                    w_gnt_valid_next = 1'b0;
                    w_hold_next      = '0;
                end else if (r_hold == HOLD_W'(HOLD_MAX)) begin
                    w_state_next     = IDLE;
                    w_gnt_next       = '0;
                    w_gnt_id_next    = '0;
                    w_gnt_valid_next = 1'b0;
                    w_hold_next      = '0;
                    w_expired_next   = 1'b1;
                    w_mask_next      = N_REQ'(1) << r_gnt_id;
                end else begin
                    w_hold_next      = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_gnt_next       = '0;
                w_gnt_id_next    = '0;
                w_gnt_valid_next = 1'b0;
                w_hold_next      = '0;
                w_mask_next      = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_expired   <= 1'b0;
            r_hold      <= '0;
            r_mask      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_gnt       <= w_gnt_next;
            r_gnt_id    <= w_gnt_id_next;
            r_gnt_valid <= w_gnt_valid_next;
            r_expired   <= w_expired_next;
            r_hold      <= w_hold_next;
            r_mask      <= w_mask_next;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign expired   = r_expired;

endmodule : prio_arbiter
`default_nettype wire

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one grant is held (legal 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  request per requester; bit 3 = highest fixed priority.
REQ-005 Port: gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-006 Port: gnt_id  output  2  encoded index of granted requester; 2'b00 when no grant.
REQ-007 Port: gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 Port: expired  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Function
REQ-009 FSM states SHALL be IDLE and GRANT only.
REQ-010 IDLE: if (req & ~mask) != 0, pick the highest eligible bit and go to GRANT; else stay IDLE.
REQ-011 Grant latency SHALL be one cycle: req sampled at edge N -> gnt/gnt_id/gnt_valid valid after edge N.
REQ-012 GRANT: gnt, gnt_id SHALL stay constant; higher-priority requests SHALL NOT preempt.
REQ-013 GRANT -> IDLE when req[gnt_id] is low at an edge; gnt clears after that edge.
REQ-014 hold_cnt SHALL load 1 on entering GRANT and increment each GRANT cycle; when hold_cnt == HOLD_MAX with req[gnt_id] still high, go to IDLE, pulse expired, set mask bit gnt_id.
REQ-015 mask SHALL affect only the next IDLE arbitration, then clear; if only the masked requester is requesting, it SHALL be granted anyway (no idle starvation).
REQ-016 Every grant SHALL be followed by at least one IDLE cycle; back-to-back grants are spaced by exactly one gnt-low cycle.
REQ-017 Request drop and expiry on the same edge: treat as drop (expired stays low, mask not set).
REQ-018 gnt SHALL never have more than one bit set; gnt_valid == |gnt always.
REQ-019 hold_cnt width: 8 bits, never wraps (saturation unreachable by REQ-014).

Reset
REQ-020 rst high at an edge: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, expired=0, hold_cnt=0, mask=0, regardless of current state.
REQ-021 Reset mid-grant SHALL drop gnt at that edge with no expired pulse; first arbitration on the first edge with rst low.

Configuration
REQ-022 Macro PRIO_ARB_RR_EN defined: priority rotates; after each grant the granted index becomes lowest, next index (mod 4) highest; rotation pointer resets to "bit 3 highest".
REQ-023 PRIO_ARB_RR_EN undefined: fixed priority 3>2>1>0 per REQ-010; no rotation pointer exists.
REQ-024 Masking (REQ-014/015) SHALL apply in both configurations.

Structure
REQ-025 Package prio_arb_pkg SHALL hold the state enum (IDLE, GRANT), N_REQ=4, ID_W=2, HOLD_W=8.
REQ-026 Combinational sub-module arb_pick SHALL take the eligible request vector plus rotation pointer and return the one-hot pick, index and any-flag; prio_arbiter holds all registers.

Verification
REQ-027 Reset: rst=1 with req=4'b1111 for 2 cycles -> gnt=0, gnt_valid=0, expired=0 throughout.
REQ-028 Priority: req=4'b0110 at edge N -> gnt=4'b0100, gnt_id=2'b10 after edge N; hold with req unchanged for 3 cycles -> gnt stable, no preemption when req becomes 4'b1110.
REQ-029 Release: drop req[2] -> one cycle gnt=0, then gnt=4'b1000, gnt_id=2'b11.
REQ-030 Expiry: HOLD_MAX=4, req=4'b0001 plus 4'b0010 held -> grant bit1 for 4 cycles, expired pulse, 1 IDLE cycle, then gnt=4'b0001 (mask); with only req[1] held -> re-granted bit1.
REQ-031 Reset mid-grant: assert rst during GRANT -> gnt=0 next edge, expired=0, re-grant one cycle after rst drops.
REQ-032 PRIO_ARB_RR_EN: req=4'b1111 with 1-cycle-held requests -> grant order 3,0,1,2,3; without macro -> 3,3,3 (each followed by one IDLE).
